node_inject_queue: RTL and testbench

Injection buffer that sits directly upstream of a mesh node's A (packet-in) port. It accepts packets from the local core and queues them in two FIFOs, one for QoS-high traffic and one for QoS-low traffic. It stamps the source ID from the node position and presents one packet at a time on the node's pkt_in valid/ready interface. It also flushes itself when its own node is power-gated.

---
 rtl/node_inject_queue.sv | 204 ++++++++++++++++++++
 tb/tb_node_inject_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/node_inject_queue.sv
// node_inject_queue: injection buffer in front of a mesh node's packet-in port.
// Core packets are queued in a high-QoS FIFO and a low-QoS FIFO. The source ID
// {VP,HP} is stamped on each packet, and one packet at a time is offered on the
// node's pkt_in valid/ready interface. The queue flushes itself while its own
// node is power-gated.
// Optional feature: define INJ_QUEUE_STARVE_EN to add a starvation counter.
// The counter forces a low grant after STARVE_LIMIT consecutive high grants
// while low traffic waits. With the macro undefined, arbitration is strict
// priority.
module node_inject_queue #(
  parameter logic [2:0] HP           = 3'b000,
  parameter logic [2:0] VP           = 3'b000,
  parameter int         DEPTH        = 4,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_vld,
  output logic                       core_rdy,
  input  logic                       core_qos,
  input  logic [1:0]                 core_type,
  input  logic [5:0]                 core_tgt,
  input  logic [7:0]                 core_data,
  output logic                       pkt_in_vld,
  input  logic                       pkt_in_rdy,
  output logic                       pkt_in_qos,
  output logic [1:0]                 pkt_in_type,
  output logic [5:0]                 pkt_in_src,
  output logic [5:0]                 pkt_in_tgt,
  output logic [7:0]                 pkt_in_data,
  input  logic                       pg_en,
  input  logic [5:0]                 pg_node,
  output logic [$clog2(DEPTH+1)-1:0] hi_cnt,
  output logic [$clog2(DEPTH+1)-1:0] lo_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [5:0] NODE_ID = {VP, HP};

  // Entry layout: {type[1:0], tgt[5:0], data[7:0]}.
  typedef logic [15:0] entry_t;

  entry_t          hi_mem_q [DEPTH];
  entry_t          hi_mem_d [DEPTH];
  entry_t          lo_mem_q [DEPTH];
  entry_t          lo_mem_d [DEPTH];
  logic [PW-1:0]   hi_wr_q, hi_wr_d, hi_rd_q, hi_rd_d;
  logic [PW-1:0]   lo_wr_q, lo_wr_d, lo_rd_q, lo_rd_d;
  logic [CW-1:0]   hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic            lock_vld_q, lock_vld_d;
  logic            lock_hi_q, lock_hi_d;

  logic            gated;
  logic            hi_ne, lo_ne, hi_full, lo_full;
  logic            force_lo;
  logic            sel_hi;
  logic            pkt_vld;
  logic            hs;
  logic            hi_push, lo_push, hi_pop, lo_pop;
  entry_t          head;
  entry_t          core_entry;

  assign gated      = pg_en && (pg_node == NODE_ID);
  assign hi_ne      = (hi_cnt_q != '0);
  assign lo_ne      = (lo_cnt_q != '0);
  assign hi_full    = (hi_cnt_q == FULL_CNT);
  assign lo_full    = (lo_cnt_q == FULL_CNT);
  assign core_entry = {core_type, core_tgt, core_data};

  // rst_n is folded in so core_rdy is low for the whole time reset is held.
  assign core_rdy = rst_n && !gated && (core_qos ? !hi_full : !lo_full);
  assign hi_push  = core_vld && core_rdy && core_qos;
  assign lo_push  = core_vld && core_rdy && !core_qos;

`ifdef INJ_QUEUE_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign force_lo = (starve_cnt_q >= LIMIT) && lo_ne;

  // Count high grants taken while low waits; a low grant or an empty low FIFO restarts it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (gated || !lo_ne || lo_pop) begin
      starve_cnt_d = '0;
    end else if (hi_pop && (starve_cnt_q != 8'hFF)) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_lo = 1'b0;
`endif

  // Arbitration and output muxing; a held lock freezes the selection during a stall.
  always_comb begin
    sel_hi  = lock_vld_q ? lock_hi_q : (hi_ne && !force_lo);
    pkt_vld = !gated && (sel_hi ? hi_ne : lo_ne);
    head    = sel_hi ? hi_mem_q[hi_rd_q] : lo_mem_q[lo_rd_q];
    hs      = pkt_vld && pkt_in_rdy;
    hi_pop  = hs && sel_hi;
    lo_pop  = hs && !sel_hi;
  end

  assign pkt_in_vld  = pkt_vld;
  assign pkt_in_qos  = pkt_vld && sel_hi;
  assign pkt_in_type = pkt_vld ? head[15:14] : 2'b00;
  assign pkt_in_tgt  = pkt_vld ? head[13:8]  : 6'h00;
  assign pkt_in_data = pkt_vld ? head[7:0]   : 8'h00;
  assign pkt_in_src  = NODE_ID;
  assign hi_cnt      = hi_cnt_q;
  assign lo_cnt      = lo_cnt_q;

  // Storage write: only the tail slot of the pushed FIFO changes.
  always_comb begin
    hi_mem_d = hi_mem_q;
    lo_mem_d = lo_mem_q;
    if (hi_push) hi_mem_d[hi_wr_q] = core_entry;
    if (lo_push) lo_mem_d[lo_wr_q] = core_entry;
  end

  // Payload storage carries no reset; occupancy counts say which slots are live.
  always_ff @(posedge clk) begin
    hi_mem_q <= hi_mem_d;
    lo_mem_q <= lo_mem_d;
  end

  // Pointer, count and lock next-state; gating flushes everything each cycle.
  always_comb begin
    hi_wr_d    = hi_wr_q;
    hi_rd_d    = hi_rd_q;
    hi_cnt_d   = hi_cnt_q;
    lo_wr_d    = lo_wr_q;
    lo_rd_d    = lo_rd_q;
    lo_cnt_d   = lo_cnt_q;
    lock_vld_d = lock_vld_q;
    lock_hi_d  = lock_hi_q;
    if (gated) begin
      hi_wr_d    = '0;
      hi_rd_d    = '0;
      hi_cnt_d   = '0;
      lo_wr_d    = '0;
      lo_rd_d    = '0;
      lo_cnt_d   = '0;
      lock_vld_d = 1'b0;
      lock_hi_d  = 1'b0;
    end else begin
      if (hi_push) hi_wr_d = hi_wr_q + 1'b1;
      if (hi_pop)  hi_rd_d = hi_rd_q + 1'b1;
      if (lo_push) lo_wr_d = lo_wr_q + 1'b1;
      if (lo_pop)  lo_rd_d = lo_rd_q + 1'b1;
      if (hi_push && !hi_pop) begin
        hi_cnt_d = hi_cnt_q + 1'b1;
      end else if (!hi_push && hi_pop) begin
        hi_cnt_d = hi_cnt_q - 1'b1;
      end
      if (lo_push && !lo_pop) begin
        lo_cnt_d = lo_cnt_q + 1'b1;
      end else if (!lo_push && lo_pop) begin
        lo_cnt_d = lo_cnt_q - 1'b1;
      end
      if (pkt_vld && !pkt_in_rdy) begin
        lock_vld_d = 1'b1;
        lock_hi_d  = sel_hi;
      end else if (hs) begin
        lock_vld_d = 1'b0;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_wr_q    <= '0;
      hi_rd_q    <= '0;
      hi_cnt_q   <= '0;
      lo_wr_q    <= '0;
      lo_rd_q    <= '0;
      lo_cnt_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_hi_q  <= 1'b0;
    end else begin
      hi_wr_q    <= hi_wr_d;
      hi_rd_q    <= hi_rd_d;
      hi_cnt_q   <= hi_cnt_d;
      lo_wr_q    <= lo_wr_d;
      lo_rd_q    <= lo_rd_d;
      lo_cnt_q   <= lo_cnt_d;
      lock_vld_q <= lock_vld_d;
      lock_hi_q  <= lock_hi_d;
    end
  end

endmodule

// File: tb/tb_node_inject_queue.sv
// Directed testbench for node_inject_queue (HP=2, VP=5, DEPTH=4, STARVE_LIMIT=8).
module tb_node_inject_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       core_vld, core_rdy, core_qos;
  logic [1:0] core_type;
  logic [5:0] core_tgt;
  logic [7:0] core_data;
  logic       pkt_in_vld, pkt_in_rdy, pkt_in_qos;
  logic [1:0] pkt_in_type;
  logic [5:0] pkt_in_src, pkt_in_tgt;
  logic [7:0] pkt_in_data;
  logic       pg_en;
  logic [5:0] pg_node;
  logic [2:0] hi_cnt, lo_cnt;

  int vec_cnt = 0;
  int mis_cnt = 0;

  always #5 clk = ~clk;

  node_inject_queue #(.HP(3'd2), .VP(3'd5), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_vld(core_vld), .core_rdy(core_rdy), .core_qos(core_qos),
    .core_type(core_type), .core_tgt(core_tgt), .core_data(core_data),
    .pkt_in_vld(pkt_in_vld), .pkt_in_rdy(pkt_in_rdy), .pkt_in_qos(pkt_in_qos),
    .pkt_in_type(pkt_in_type), .pkt_in_src(pkt_in_src), .pkt_in_tgt(pkt_in_tgt),
    .pkt_in_data(pkt_in_data), .pg_en(pg_en), .pg_node(pg_node),
    .hi_cnt(hi_cnt), .lo_cnt(lo_cnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_vld = 1'b0; core_qos = 1'b0; core_type = 2'd0;
    core_tgt = 6'd0; core_data = 8'd0; pkt_in_rdy = 1'b0; pg_en = 1'b0; pg_node = 6'd0;
    #12;
    vec_cnt++; if (core_rdy !== 1'b0) begin mis_cnt++; $display("FAIL rst_core_rdy got %b exp 0", core_rdy); end
    vec_cnt++; if (pkt_in_vld !== 1'b0) begin mis_cnt++; $display("FAIL rst_vld got %b exp 0", pkt_in_vld); end
    vec_cnt++; if ({pkt_in_qos, pkt_in_type, pkt_in_tgt, pkt_in_data} !== 17'd0) begin mis_cnt++; $display("FAIL rst_fields got %h exp 0", {pkt_in_qos, pkt_in_type, pkt_in_tgt, pkt_in_data}); end
    vec_cnt++; if ({hi_cnt, lo_cnt} !== 6'd0) begin mis_cnt++; $display("FAIL rst_cnts got %h exp 0", {hi_cnt, lo_cnt}); end
    vec_cnt++; if (pkt_in_src !== 6'h2A) begin mis_cnt++; $display("FAIL rst_src got %h exp 2a", pkt_in_src); end
    @(negedge clk); rst_n = 1'b1;
    next_cycle(); #2;
    vec_cnt++; if (core_rdy !== 1'b1) begin mis_cnt++; $display("FAIL post_rst_core_rdy got %b exp 1", core_rdy); end
  endtask

  task automatic test_basic();
    next_cycle();
    core_vld = 1'b1; core_qos = 1'b0; core_type = 2'd2; core_tgt = 6'h11; core_data = 8'hA5; pkt_in_rdy = 1'b1;
    #2;
    vec_cnt++; if (core_rdy !== 1'b1) begin mis_cnt++; $display("FAIL basic_core_rdy got %b exp 1", core_rdy); end
    vec_cnt++; if (pkt_in_vld !== 1'b0) begin mis_cnt++; $display("FAIL basic_no_bypass got %b exp 0", pkt_in_vld); end
    vec_cnt++; if (lo_cnt !== 3'd0) begin mis_cnt++; $display("FAIL basic_lo_cnt0 got %0d exp 0", lo_cnt); end
    next_cycle(); core_vld = 1'b0; #2;
    vec_cnt++; if (pkt_in_vld !== 1'b1) begin mis_cnt++; $display("FAIL basic_vld got %b exp 1", pkt_in_vld); end
    vec_cnt++; if ({pkt_in_src, pkt_in_tgt, pkt_in_data} !== {6'h2A, 6'h11, 8'hA5}) begin mis_cnt++; $display("FAIL basic_fields got %h exp %h", {pkt_in_src, pkt_in_tgt, pkt_in_data}, {6'h2A, 6'h11, 8'hA5}); end
    vec_cnt++; if ({pkt_in_qos, pkt_in_type} !== 3'b010) begin mis_cnt++; $display("FAIL basic_qos_type got %b exp 010", {pkt_in_qos, pkt_in_type}); end
    vec_cnt++; if (lo_cnt !== 3'd1) begin mis_cnt++; $display("FAIL basic_lo_cnt1 got %0d exp 1", lo_cnt); end
    next_cycle(); #2;
    vec_cnt++; if (pkt_in_vld !== 1'b0) begin mis_cnt++; $display("FAIL basic_vld_after got %b exp 0", pkt_in_vld); end
    vec_cnt++; if (lo_cnt !== 3'd0) begin mis_cnt++; $display("FAIL basic_lo_cnt_after got %0d exp 0", lo_cnt); end
  endtask

  task automatic test_full();
    pkt_in_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      core_vld = 1'b1; core_qos = 1'b1; core_type = 2'd1; core_tgt = 6'h03; core_data = 8'h10 + 8'(i);
      #2;
      vec_cnt++; if (core_rdy !== (i < 4)) begin mis_cnt++; $display("FAIL full_core_rdy[%0d] got %b exp %b", i, core_rdy, (i < 4)); end
      vec_cnt++; if (hi_cnt !== 3'(i)) begin mis_cnt++; $display("FAIL full_hi_cnt[%0d] got %0d exp %0d", i, hi_cnt, i); end
      if (i > 0) begin
        vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b11, 8'h10}) begin mis_cnt++; $display("FAIL full_stall_fields[%0d] got %h exp 310", i, {pkt_in_vld, pkt_in_qos, pkt_in_data}); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); core_vld = 1'b0; #2;
      vec_cnt++; if ({pkt_in_vld, pkt_in_data, hi_cnt} !== {1'b1, 8'h10, 3'd4}) begin mis_cnt++; $display("FAIL full_hold[%0d] got %h exp %h", i, {pkt_in_vld, pkt_in_data, hi_cnt}, {1'b1, 8'h10, 3'd4}); end
    end
    for (int j = 0; j < 4; j++) begin
      next_cycle(); pkt_in_rdy = 1'b1; #2;
      vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b11, 8'h10 + 8'(j)}) begin mis_cnt++; $display("FAIL full_drain[%0d] got %h exp %h", j, {pkt_in_vld, pkt_in_qos, pkt_in_data}, {2'b11, 8'h10 + 8'(j)}); end
    end
    next_cycle(); #2;
    vec_cnt++; if ({pkt_in_vld, hi_cnt} !== 4'd0) begin mis_cnt++; $display("FAIL full_empty got %h exp 0", {pkt_in_vld, hi_cnt}); end
  endtask

  task automatic test_lock();
    pkt_in_rdy = 1'b0;
    next_cycle(); core_vld = 1'b1; core_qos = 1'b0; core_data = 8'h30; #2;
    next_cycle(); core_qos = 1'b1; core_data = 8'h40; #2;
    vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b10, 8'h30}) begin mis_cnt++; $display("FAIL lock_lo_shown got %h exp 230", {pkt_in_vld, pkt_in_qos, pkt_in_data}); end
    next_cycle(); core_vld = 1'b0; #2;
    vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b10, 8'h30}) begin mis_cnt++; $display("FAIL lock_held got %h exp 230", {pkt_in_vld, pkt_in_qos, pkt_in_data}); end
    vec_cnt++; if (hi_cnt !== 3'd1) begin mis_cnt++; $display("FAIL lock_hi_cnt got %0d exp 1", hi_cnt); end
    next_cycle(); pkt_in_rdy = 1'b1; #2;
    vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b10, 8'h30}) begin mis_cnt++; $display("FAIL lock_hs got %h exp 230", {pkt_in_vld, pkt_in_qos, pkt_in_data}); end
    next_cycle(); #2;
    vec_cnt++; if ({pkt_in_vld, pkt_in_qos, pkt_in_data} !== {2'b11, 8'h40}) begin mis_cnt++; $display("FAIL lock_hi_next got %h exp 340", {pkt_in_vld, pkt_in_qos, pkt_in_data}); end
    next_cycle(); #2;
    vec_cnt++; if (pkt_in_vld !== 1'b0) begin mis_cnt++; $display("FAIL lock_empty got %b exp 0", pkt_in_vld); end
  endtask

  task automatic test_gate();
    pkt_in_rdy = 1'b0;
    next_cycle(); core_vld = 1'b1; core_qos = 1'b1; core_data = 8'h50; #2;
    next_cycle(); core_data = 8'h51; #2;
    next_cycle(); core_qos = 1'b0; core_data = 8'h52; #2;
    next_cycle(); core_vld = 1'b0; #2;
    vec_cnt++; if ({hi_cnt, lo_cnt, pkt_in_vld, pkt_in_data} !== {3'd2, 3'd1, 1'b1, 8'h50}) begin mis_cnt++; $display("FAIL gate_queued got %h exp %h", {hi_cnt, lo_cnt, pkt_in_vld, pkt_in_data}, {3'd2, 3'd1, 1'b1, 8'h50}); end
    next_cycle(); pg_en = 1'b1; pg_node = 6'h15; core_vld = 1'b1; core_qos = 1'b0; core_data = 8'h53; #2;
    vec_cnt++; if ({pkt_in_vld, core_rdy} !== 2'b11) begin mis_cnt++; $display("FAIL gate_other_node got %b exp 11", {pkt_in_vld, core_rdy}); end
    next_cycle(); pg_en = 1'b0; core_vld = 1'b0; #2;
    vec_cnt++; if ({hi_cnt, lo_cnt} !== {3'd2, 3'd2}) begin mis_cnt++; $display("FAIL gate_other_cnts got %h exp 12", {hi_cnt, lo_cnt}); end
    next_cycle(); pg_en = 1'b1; pg_node = 6'h2A; core_vld = 1'b1; #2;
    vec_cnt++; if ({pkt_in_vld, core_rdy} !== 2'b00) begin mis_cnt++; $display("FAIL gate_own_node got %b exp 00", {pkt_in_vld, core_rdy}); end
    next_cycle(); pg_en = 1'b0; core_vld = 1'b0; #2;
    vec_cnt++; if ({hi_cnt, lo_cnt, pkt_in_vld} !== 7'd0) begin mis_cnt++; $display("FAIL gate_flushed got %h exp 0", {hi_cnt, lo_cnt, pkt_in_vld}); end
    vec_cnt++; if (core_rdy !== 1'b1) begin mis_cnt++; $display("FAIL gate_resume got %b exp 1", core_rdy); end
  endtask

  task automatic test_starve();
    int lo_grants;
    int k;
    logic exp_qos;
    pkt_in_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      next_cycle(); core_vld = 1'b1; core_qos = (i < 4); core_data = 8'(i); #2;
    end
    next_cycle(); core_vld = 1'b0; #2;
    vec_cnt++; if ({hi_cnt, lo_cnt} !== {3'd4, 3'd4}) begin mis_cnt++; $display("FAIL starve_prefill got %h exp 24", {hi_cnt, lo_cnt}); end
    lo_grants = 0;
    k = 0;
    for (int c = 0; c < 40 && k < 27; c++) begin
      next_cycle();
      pkt_in_rdy = 1'b1; core_vld = 1'b1; core_qos = (hi_cnt != 3'd4);
      #2;
      if (pkt_in_vld && pkt_in_rdy) begin
`ifdef INJ_QUEUE_STARVE_EN
        exp_qos = ((k % 9) != 8);
`else
        exp_qos = 1'b1;
`endif
        vec_cnt++; if (pkt_in_qos !== exp_qos) begin mis_cnt++; $display("FAIL starve_grant[%0d] got qos %b exp %b", k, pkt_in_qos, exp_qos); end
        if (!pkt_in_qos) lo_grants++;
        k++;
      end
    end
    vec_cnt++; if (k != 27) begin mis_cnt++; $display("FAIL starve_grant_count got %0d exp 27", k); end
`ifdef INJ_QUEUE_STARVE_EN
    vec_cnt++; if (lo_grants != 3) begin mis_cnt++; $display("FAIL starve_lo_grants got %0d exp 3", lo_grants); end
`else
    vec_cnt++; if (lo_grants != 0) begin mis_cnt++; $display("FAIL starve_lo_grants got %0d exp 0", lo_grants); end
`endif
    next_cycle(); core_vld = 1'b0;
    for (int c = 0; c < 20 && (hi_cnt != 0 || lo_cnt != 0); c++) next_cycle();
    #2;
    vec_cnt++; if ({hi_cnt, lo_cnt} !== 6'd0) begin mis_cnt++; $display("FAIL starve_drain got %h exp 0", {hi_cnt, lo_cnt}); end
  endtask

  task automatic test_async_reset();
    pkt_in_rdy = 1'b0;
    next_cycle(); core_vld = 1'b1; core_qos = 1'b1; core_data = 8'h60; #2;
    next_cycle(); core_vld = 1'b0; #2;
    vec_cnt++; if ({pkt_in_vld, pkt_in_data} !== {1'b1, 8'h60}) begin mis_cnt++; $display("FAIL arst_pre got %h exp 160", {pkt_in_vld, pkt_in_data}); end
    #1; rst_n = 1'b0; #1;
    vec_cnt++; if ({pkt_in_vld, core_rdy, hi_cnt} !== 5'd0) begin mis_cnt++; $display("FAIL arst_immediate got %h exp 0", {pkt_in_vld, core_rdy, hi_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    next_cycle(); #2;
    vec_cnt++; if ({pkt_in_vld, hi_cnt, lo_cnt, core_rdy} !== 8'd1) begin mis_cnt++; $display("FAIL arst_release got %h exp 01", {pkt_in_vld, hi_cnt, lo_cnt, core_rdy}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_lock();
    test_gate();
    test_starve();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
